// File: rtl/mips_pkg.sv
// mips_pkg: shared fetch-path constants and the fetch-packet type
package mips_pkg;
    localparam logic [31:0] RESET_PC  = 32'h0000_3000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_pkt_t;
endpackage

// File: rtl/instr_fetch_queue_storage.sv
// fq_storage: DEPTH x 64-bit register array, one write port, one async read port
module fq_storage
    import mips_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [PTR_W-1:0] waddr,
    input  fetch_pkt_t       wdata,
    input  logic [PTR_W-1:0] raddr,
    output fetch_pkt_t       rdata
);
    fetch_pkt_t r_mem [DEPTH];
    // Capture the pushed packet; contents are never cleared, occupancy lives in the parent
    always_ff @(posedge clk) begin
        if (we) r_mem[waddr] <= wdata;
    end
    assign rdata = r_mem[raddr];
endmodule

// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: fetch-to-decode FIFO of {pc, instr} pairs with flush on redirect
module instr_fetch_queue
    import mips_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             f_valid,
    input  logic [31:0]      f_pc,
    input  logic [31:0]      f_instr,
    output logic             f_ready,
    output logic             d_valid,
    output logic [31:0]      d_pc,
    output logic [31:0]      d_instr,
    input  logic             d_ready,
    output logic [PTR_W:0]   count
);
    localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic             w_push;
    logic             w_pop;
    fetch_pkt_t       w_head;

    fq_storage #(.DEPTH(DEPTH)) u_storage (
        .clk   (clk),
        .we    (w_push),
        .waddr (r_wr_ptr),
        .wdata ({f_pc, f_instr}),
        .raddr (r_rd_ptr),
        .rdata (w_head)
    );

    // Handshake and head presentation; a flushing cycle hides the head so decode cannot consume it
    always_comb begin
        f_ready = r_count != FULL;
        d_valid = (r_count != '0) & ~flush;
        w_push  = f_valid & f_ready & ~flush;
        w_pop   = d_valid & d_ready;
        d_pc    = d_valid ? w_head.pc : 32'h0000_0000;
        d_instr = d_valid ? w_head.instr : NOP_INSTR;
        count   = r_count;
    end

    // Pointer and occupancy update; reset beats flush, flush beats push/pop
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_rd_ptr <= r_wr_ptr;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + {{PTR_W{1'b0}}, w_push} - {{PTR_W{1'b0}}, w_pop};
        end
    end
endmodule

// File: tb/tb_instr_fetch_queue.sv
// tb_instr_fetch_queue: directed plus random stimulus against a queue-based reference model
module tb_instr_fetch_queue;
    import mips_pkg::*;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        f_valid = 1'b0;
    logic [31:0] f_pc = '0;
    logic [31:0] f_instr = '0;
    logic        f_ready;
    logic        d_valid;
    logic [31:0] d_pc;
    logic [31:0] d_instr;
    logic        d_ready = 1'b0;
    logic [2:0]  count;

    int total = 0;
    int bad = 0;
    fetch_pkt_t q[$];

    instr_fetch_queue #(.DEPTH(DEPTH)) dut (
        .clk     (clk),
        .reset   (reset),
        .flush   (flush),
        .f_valid (f_valid),
        .f_pc    (f_pc),
        .f_instr (f_instr),
        .f_ready (f_ready),
        .d_valid (d_valid),
        .d_pc    (d_pc),
        .d_instr (d_instr),
        .d_ready (d_ready),
        .count   (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One cycle: drive at the falling edge, check combinational outputs, then apply the edge to the model
    task automatic step(input bit fv, input logic [31:0] pc, input bit dr, input bit fl, input bit rs);
        bit ev, push, pop;
        fetch_pkt_t pkt;
        @(negedge clk);
        pkt.pc    = pc;
        pkt.instr = $urandom;
        f_valid = fv;
        f_pc    = pkt.pc;
        f_instr = pkt.instr;
        d_ready = dr;
        flush   = fl;
        reset   = rs;
        #1;
        ev = (q.size() != 0) && !fl;
        check("count", 32'(count), 32'(q.size()));
        check("count_le_depth", 32'(count <= DEPTH), 32'd1);
        check("f_ready", 32'(f_ready), 32'(q.size() != DEPTH));
        check("d_valid", 32'(d_valid), 32'(ev));
        check("d_pc", d_pc, ev ? q[0].pc : 32'h0);
        check("d_instr", d_instr, ev ? q[0].instr : NOP_INSTR);
        push = fv && (q.size() != DEPTH) && !fl;
        pop  = ev && dr;
        @(posedge clk);
        if (rs || fl) q.delete();
        else begin
            if (pop) void'(q.pop_front());
            if (push) q.push_back(pkt);
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        // reset then idle
        step(0, 0, 0, 0, 0);
        // fill to four, refused fifth push, drain in order
        for (int i = 0; i < 4; i++) step(1, RESET_PC + 32'(4*i), 0, 0, 0);
        step(1, 32'h3010, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0);
        // steady streaming
        for (int i = 0; i < 8; i++) step(1, RESET_PC + 32'(4*i), 1, 0, 0);
        for (int i = 0; i < 2; i++) step(0, 0, 1, 0, 0);
        // full with simultaneous pop: pop accepted, push refused
        for (int i = 0; i < 4; i++) step(1, RESET_PC + 32'(4*i), 0, 0, 0);
        step(1, 32'h3010, 1, 0, 0);
        step(0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0);
        // flush with simultaneous push; later push becomes head
        for (int i = 0; i < 3; i++) step(1, RESET_PC + 32'(4*i), 0, 0, 0);
        step(1, 32'h300C, 1, 1, 0);
        step(1, 32'h4000, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0);
        // pointer wrap with push/pop pairs, then reset mid-stream
        step(1, RESET_PC, 0, 0, 0);
        for (int i = 1; i < 10; i++) step(1, RESET_PC + 32'(4*i), 1, 0, 0);
        step(1, 32'h3028, 0, 0, 0);
        step(0, 0, 1, 1, 1);
        step(0, 0, 0, 0, 0);
        // random traffic
        for (int i = 0; i < 300; i++)
            step($urandom_range(3) != 0, {$urandom_range(32'hFFFF), 2'b00}, $urandom_range(2) != 0,
                 $urandom_range(15) == 0, $urandom_range(49) == 0);
        step(0, 0, 0, 0, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
